// File: rtl/sync_mem_rr_pkg.sv
// Shared constants and types for the round-robin memory access controller.
package sync_mem_rr_pkg;
   localparam int MAX_CLIENTS = 8;
   localparam int STAT_WIDTH  = 16;
   typedef logic [2:0] client_idx_t;
endpackage

// File: rtl/sync_mem_rr_ctrl_rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first requester at or after the pointer.
module rr_arbiter
   import sync_mem_rr_pkg::*;
#(
   parameter int N = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [N-1:0] req,
   output logic [N-1:0] grant,
   output client_idx_t ptr_q
);

   logic [2*N-1:0] dbl_s;
   logic [N-1:0]   rot_s;
   logic           any_s;
   client_idx_t    off_s;
   client_idx_t    gidx_s;
   client_idx_t    ptr_d;
   logic [3:0]     sum_s;
   logic [3:0]     nxt_s;

   // Rotate requests so the pointer sits at bit 0, pick the lowest set bit, rotate back.
   always_comb begin
      dbl_s = {req, req} >> ptr_q;
      rot_s = dbl_s[N-1:0];
      any_s = |rot_s;
      off_s = '0;
      for (int k = N - 1; k >= 0; k--) begin
         off_s = rot_s[k] ? client_idx_t'(k) : off_s;
      end
      sum_s  = {1'b0, ptr_q} + {1'b0, off_s};
      sum_s  = (sum_s >= 4'(N)) ? (sum_s - 4'(N)) : sum_s;
      gidx_s = sum_s[2:0];
      nxt_s  = {1'b0, gidx_s} + 4'd1;
      nxt_s  = (nxt_s >= 4'(N)) ? 4'd0 : nxt_s;
      if (any_s) begin
         grant = N'(1) << gidx_s;
         ptr_d = nxt_s[2:0];
      end else begin
         grant = '0;
         ptr_d = ptr_q;
      end
   end

   // Pointer register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr_q <= '0;
      end else begin
         ptr_q <= ptr_d;
      end
   end

endmodule

// File: rtl/sync_mem_rr_ctrl.sv
// Shares one 1W/1R synchronous memory among NUM_CLIENTS requesters with independent RR arbiters.
// Optional stall statistics counter enabled by SYNC_MEM_RR_CTRL_STATS_EN.
module sync_mem_rr_ctrl
   import sync_mem_rr_pkg::*;
#(
   parameter int ADDR_WIDTH  = 4,
   parameter int DATA_WIDTH  = 8,
   parameter int NUM_CLIENTS = 2
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic [NUM_CLIENTS-1:0]            req_valid,
   input  logic [NUM_CLIENTS-1:0]            req_we,
   input  logic [NUM_CLIENTS*ADDR_WIDTH-1:0] req_addr,
   input  logic [NUM_CLIENTS*DATA_WIDTH-1:0] req_wdata,
   output logic [NUM_CLIENTS-1:0]            req_ready,
   output logic [NUM_CLIENTS-1:0]            rsp_valid,
   output logic [DATA_WIDTH-1:0]             rsp_data,
   output logic                              mem_wr_en,
   output logic [ADDR_WIDTH-1:0]             mem_wr_addr,
   output logic [DATA_WIDTH-1:0]             mem_wr_data,
   output logic [ADDR_WIDTH-1:0]             mem_rd_addr,
   input  logic [DATA_WIDTH-1:0]             mem_rd_data
`ifdef SYNC_MEM_RR_CTRL_STATS_EN
   ,
   output logic [STAT_WIDTH-1:0]             stat_stall_cnt
`endif
);

   logic [NUM_CLIENTS-1:0] wr_req_s;
   logic [NUM_CLIENTS-1:0] rd_req_s;
   logic [NUM_CLIENTS-1:0] wr_grant_s;
   logic [NUM_CLIENTS-1:0] rd_grant_s;
   logic [NUM_CLIENTS-1:0] rsp_valid_q;
   logic [NUM_CLIENTS-1:0] rsp_valid_d;
   client_idx_t            wr_ptr_s;
   client_idx_t            rd_ptr_s;

   // Masking requests during reset forces every grant, and so every memory-side output, to zero.
   always_comb begin
      wr_req_s = req_valid & req_we  & {NUM_CLIENTS{~rst}};
      rd_req_s = req_valid & ~req_we & {NUM_CLIENTS{~rst}};
   end

   rr_arbiter #(.N(NUM_CLIENTS)) u_wr_arb (
      .clk   (clk),
      .rst   (rst),
      .req   (wr_req_s),
      .grant (wr_grant_s),
      .ptr_q (wr_ptr_s)
   );

   rr_arbiter #(.N(NUM_CLIENTS)) u_rd_arb (
      .clk   (clk),
      .rst   (rst),
      .req   (rd_req_s),
      .grant (rd_grant_s),
      .ptr_q (rd_ptr_s)
   );

   // One-hot AND-OR muxes select the granted client's address and data.
   always_comb begin
      mem_wr_addr = '0;
      mem_wr_data = '0;
      mem_rd_addr = '0;
      for (int i = 0; i < NUM_CLIENTS; i++) begin
         mem_wr_addr = mem_wr_addr | (req_addr[i*ADDR_WIDTH +: ADDR_WIDTH]  & {ADDR_WIDTH{wr_grant_s[i]}});
         mem_wr_data = mem_wr_data | (req_wdata[i*DATA_WIDTH +: DATA_WIDTH] & {DATA_WIDTH{wr_grant_s[i]}});
         mem_rd_addr = mem_rd_addr | (req_addr[i*ADDR_WIDTH +: ADDR_WIDTH]  & {ADDR_WIDTH{rd_grant_s[i]}});
      end
      mem_wr_en   = |wr_grant_s;
      req_ready   = wr_grant_s | rd_grant_s;
      rsp_valid_d = rd_grant_s;
      rsp_valid   = rsp_valid_q;
      rsp_data    = mem_rd_data;
   end

   // Read tag: the read grant one cycle late lines up with the memory's registered data.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rsp_valid_q <= '0;
      end else begin
         rsp_valid_q <= rsp_valid_d;
      end
   end

`ifdef SYNC_MEM_RR_CTRL_STATS_EN
   logic [STAT_WIDTH-1:0] stat_q;
   logic [STAT_WIDTH-1:0] stat_d;
   logic                  stall_s;

   // Saturating count of cycles where some valid request went ungranted.
   always_comb begin
      stall_s = |(req_valid & ~req_ready);
      stat_d  = (stall_s && (stat_q != 16'hFFFF)) ? (stat_q + 16'd1) : stat_q;
      stat_stall_cnt = stat_q;
   end

   // Statistics register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stat_q <= '0;
      end else begin
         stat_q <= stat_d;
      end
   end
`endif

endmodule

// File: doc/sync_mem_rr_ctrl.md
Name: sync_mem_rr_ctrl

Overview:
Round-robin access controller that shares one dual-port synchronous memory (one write port, one read port, 1-cycle registered read, same-cycle write-to-read forwarding) between NUM_CLIENTS requesters. Each cycle it grants at most one write and at most one read, from independent round-robin arbiters. It routes read data back to the issuing client and adds no latency beyond the memory's own. It sits between client valid/ready interfaces and the memory instance.

Parameters:
ADDR_WIDTH, 4, memory address width
DATA_WIDTH, 8, memory data width
NUM_CLIENTS, 2, number of requesters; legal range 2..8

Ports:
clk  in  1  clock; all state on rising edge
rst  in  1  asynchronous active-high reset
req_valid  in  NUM_CLIENTS  per-client request valid
req_we  in  NUM_CLIENTS  per-client op: 1=write, 0=read
req_addr  in  NUM_CLIENTS*ADDR_WIDTH  packed addresses; client i at slice i
req_wdata  in  NUM_CLIENTS*DATA_WIDTH  packed write data
req_ready  out  NUM_CLIENTS  per-client grant; transfer = valid&&ready
rsp_valid  out  NUM_CLIENTS  one-hot read-response strobe
rsp_data  out  DATA_WIDTH  read data, shared by all clients
mem_wr_en  out  1  memory write enable
mem_wr_addr  out  ADDR_WIDTH  memory write address
mem_wr_data  out  DATA_WIDTH  memory write data
mem_rd_addr  out  ADDR_WIDTH  memory read address
mem_rd_data  in  DATA_WIDTH  memory registered read data

Behaviour:
- Reset (async, rst=1): rr pointers=0, rsp_valid=0, rd-tag register cleared. While rst=1: req_ready=0, mem_wr_en=0, mem_wr_addr/mem_rd_addr=0, mem_wr_data=0.
- Client rule: one request per client per cycle. Once valid, hold we/addr/wdata stable until ready. No combinational valid-from-ready path allowed in clients.
- Write arbiter: candidates = req_valid & req_we. Grant the first candidate at or after wr_ptr (circular). mem_wr_en=1 combinationally; mem_wr_addr/data muxed from the grantee. Write commits on that clk edge.
- Read arbiter: candidates = req_valid & ~req_we, with the same scheme on rd_ptr. mem_rd_addr is muxed from the grantee. With no read grant, mem_rd_addr=0 and no response is generated.
- Pointer update: on a grant, ptr <= (grantee+1) mod NUM_CLIENTS. With no grant, ptr holds. Pointers are independent per port.
- req_ready = wr_grant | rd_grant (combinational, one-hot per port).
- Read latency: read handshake in cycle N gives rsp_valid[grantee]=1 in cycle N+1 only. rsp_data = mem_rd_data (pass-through); rsp_data is don't-care when rsp_valid=0.
- Back-to-back reads: one per cycle sustained. Responses return in issue order.
- Same cycle, write addr A by client i and read addr A by client j: both granted. The response returns the newly written data (memory forwarding).
- Starvation bound: a continuously valid client waits at most NUM_CLIENTS-1 cycles per port.
- Reset mid-operation: an in-flight read response is dropped (rsp_valid forced 0). Memory contents are not touched by this block.

Optional Feature:
SYNC_MEM_RR_CTRL_STATS_EN
- Defined: adds output stat_stall_cnt (16 bits), a saturating count of cycles in which at least one valid request was not granted. Cleared by rst; holds at 16'hFFFF once saturated.
- Undefined: the port and counter are absent; all other behaviour is identical.

Decomposition:
- Package sync_mem_rr_pkg holds MAX_CLIENTS=8, STAT_WIDTH=16, and the client-index typedef (3 bits).
- Sub-module rr_arbiter takes a req vector and produces a one-hot grant and the registered pointer. It is instantiated twice, once for the write port and once for the read port.

Test Plan:
- Reset: assert rst mid-read (read issued, rst before next edge). Expect rsp_valid=0, mem_wr_en=0, req_ready=0 while rst=1.
- Single client 0 writes A=4'ha, D=8'haa, then reads 4'ha. Expect ready same cycle; rsp_valid=2'b01, rsp_data=8'haa one cycle after the read handshake.
- Both clients write continuously (c0→4'h1, c1→4'h2). Expect grants alternate c0,c1,c0,c1 from reset; each waits at most 1 cycle.
- c0 writes 4'h5/8'hff while c1 reads 4'h5 (old value 8'h11) in the same cycle. Expect both ready; next cycle rsp_valid=2'b10, rsp_data=8'hff.
- c0 reads 4'h0 (holds 8'hcc) and c1 reads 4'ha (8'haa), both valid. Expect c0 granted first, then c1 in the following cycle. Responses 8'hcc→c0 then 8'haa→c1 on consecutive cycles.
- STATS_EN: keep 2 writers contending for 10 cycles. Expect stat_stall_cnt=10; preload near 16'hFFFF and confirm it saturates.
